// File: rtl/mult_pipe_if.sv
// rtl/mult_pipe_if.sv - operand/result handshake bundle for mult_pipe (out_overflow only with MULT_PIPE_OVF_EN)
interface mult_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic [TAG_W-1:0]   out_tag;
    logic               out_iszero;
    logic               out_ispositive;
`ifdef MULT_PIPE_OVF_EN
    logic               out_overflow;
`endif

    modport slave (
`ifdef MULT_PIPE_OVF_EN
        output out_overflow,
`endif
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag, out_iszero, out_ispositive
    );

    modport master (
`ifdef MULT_PIPE_OVF_EN
        input  out_overflow,
`endif
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag, out_iszero, out_ispositive
    );
endinterface

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - elastic pipelined signed/unsigned multiplier; MULT_PIPE_OVF_EN adds out_overflow
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    flush,
    mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int L  = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_adv;
    logic              w_accept;

    logic [WIDTH-1:0]  r_mag_a;
    logic [WIDTH-1:0]  r_mag_b;
    logic              r_neg0;
    logic              r_zero0;
    logic [TAG_W-1:0]  r_tag0;

    logic [PW-1:0]     r_prod [1:L];
    logic              r_neg  [1:L];
    logic              r_zero [1:L];
    logic [TAG_W-1:0]  r_tag  [1:L];

`ifdef MULT_PIPE_OVF_EN
    logic              r_sgn0;
    logic              r_sgn  [1:L];
`endif

    logic              w_neg_a;
    logic              w_neg_b;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic [PW-1:0]     w_mag_prod;
    logic [PW-1:0]     w_prod_out;

    // A stage may move when some stage above it is empty or the consumer takes the head.
    always_comb begin
        logic room;
        w_adv = '0;
        room  = bus.out_ready;
        for (int i = L; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & room;
            room     = room | ~r_valid[i];
        end
    end

    assign bus.in_ready = ~r_valid[0] | w_adv[0];
    assign w_accept     = bus.in_valid & bus.in_ready;

    assign w_neg_a    = bus.in_signed & bus.in_a[WIDTH-1];
    assign w_neg_b    = bus.in_signed & bus.in_b[WIDTH-1];
    assign w_abs_a    = w_neg_a ? -bus.in_a : bus.in_a;
    assign w_abs_b    = w_neg_b ? -bus.in_b : bus.in_b;
    assign w_mag_prod = PW'(r_mag_a) * PW'(r_mag_b);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg0  <= 1'b0;
            r_zero0 <= 1'b0;
            r_tag0  <= '0;
`ifdef MULT_PIPE_OVF_EN
            r_sgn0  <= 1'b0;
`endif
            for (int i = 1; i < STAGES; i++) begin
                r_prod[i] <= '0;
                r_neg[i]  <= 1'b0;
                r_zero[i] <= 1'b0;
                r_tag[i]  <= '0;
`ifdef MULT_PIPE_OVF_EN
                r_sgn[i]  <= 1'b0;
`endif
            end
        end else if (flush) begin
            r_valid <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg0  <= 1'b0;
            r_zero0 <= 1'b0;
            r_tag0  <= '0;
`ifdef MULT_PIPE_OVF_EN
            r_sgn0  <= 1'b0;
`endif
            for (int i = 1; i < STAGES; i++) begin
                r_prod[i] <= '0;
                r_neg[i]  <= 1'b0;
                r_zero[i] <= 1'b0;
                r_tag[i]  <= '0;
`ifdef MULT_PIPE_OVF_EN
                r_sgn[i]  <= 1'b0;
`endif
            end
        end else begin
            if (w_accept) begin
                r_valid[0] <= 1'b1;
                r_mag_a    <= w_abs_a;
                r_mag_b    <= w_abs_b;
                r_neg0     <= w_neg_a ^ w_neg_b;
                r_zero0    <= (bus.in_a == '0) | (bus.in_b == '0);
                r_tag0     <= bus.in_tag;
`ifdef MULT_PIPE_OVF_EN
                r_sgn0     <= bus.in_signed;
`endif
            end else if (w_adv[0] || !r_valid[0]) begin
                r_valid[0] <= 1'b0;
                r_mag_a    <= '0;
                r_mag_b    <= '0;
                r_neg0     <= 1'b0;
                r_zero0    <= 1'b0;
                r_tag0     <= '0;
`ifdef MULT_PIPE_OVF_EN
                r_sgn0     <= 1'b0;
`endif
            end

            if (w_adv[0]) begin
                r_valid[1] <= 1'b1;
                r_prod[1]  <= w_mag_prod;
                r_neg[1]   <= r_neg0;
                r_zero[1]  <= r_zero0;
                r_tag[1]   <= r_tag0;
`ifdef MULT_PIPE_OVF_EN
                r_sgn[1]   <= r_sgn0;
`endif
            end else if (w_adv[1] || !r_valid[1]) begin
                r_valid[1] <= 1'b0;
                r_prod[1]  <= '0;
                r_neg[1]   <= 1'b0;
                r_zero[1]  <= 1'b0;
                r_tag[1]   <= '0;
`ifdef MULT_PIPE_OVF_EN
                r_sgn[1]   <= 1'b0;
`endif
            end

            // Remaining stages only delay the product so the multiplier can be retimed across them.
            for (int i = 2; i < STAGES; i++) begin
                if (w_adv[i-1]) begin
                    r_valid[i] <= 1'b1;
                    r_prod[i]  <= r_prod[i-1];
                    r_neg[i]   <= r_neg[i-1];
                    r_zero[i]  <= r_zero[i-1];
                    r_tag[i]   <= r_tag[i-1];
`ifdef MULT_PIPE_OVF_EN
                    r_sgn[i]   <= r_sgn[i-1];
`endif
                end else if (w_adv[i] || !r_valid[i]) begin
                    r_valid[i] <= 1'b0;
                    r_prod[i]  <= '0;
                    r_neg[i]   <= 1'b0;
                    r_zero[i]  <= 1'b0;
                    r_tag[i]   <= '0;
`ifdef MULT_PIPE_OVF_EN
                    r_sgn[i]   <= 1'b0;
`endif
                end
            end
        end
    end

    // Data registers are zero in an empty stage, so the negate never leaks a value.
    assign w_prod_out         = r_neg[L] ? -r_prod[L] : r_prod[L];
    assign bus.out_valid      = r_valid[L];
    assign bus.out_prod       = w_prod_out;
    assign bus.out_tag        = r_tag[L];
    assign bus.out_iszero     = r_zero[L];
    assign bus.out_ispositive = r_valid[L] & ~r_zero[L] & ~r_neg[L];

`ifdef MULT_PIPE_OVF_EN
    logic [WIDTH:0] w_hi_s;
    assign w_hi_s = w_prod_out[PW-1:WIDTH-1];
    assign bus.out_overflow = r_valid[L] &
        (r_sgn[L] ? ~((&w_hi_s) | ~(|w_hi_s)) : (|w_prod_out[PW-1:WIDTH]));
`endif
endmodule

// File: tb/tb_mult_pipe.sv
// tb/tb_mult_pipe.sv - directed bench for mult_pipe with an arithmetic scoreboard model
module tb_mult_pipe;
    localparam int W = 32;
    localparam int S = 3;
    localparam int T = 5;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [63:0] prod;
        logic [4:0]  tag;
        logic        zero;
        logic        pos;
        logic        ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    mult_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

    mult_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic [4:0] seen_tags[$];
    logic last_ovf = 1'b0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag);
        exp_t   e;
        longint sp;
        e.tag = tag;
        if (sgn) begin
            sp     = longint'($signed(a)) * longint'($signed(b));
            e.prod = sp;
            e.pos  = sp > 0;
            e.ovf  = (sp > SMAX) || (sp < SMIN);
        end else begin
            e.prod = {32'b0, a} * {32'b0, b};
            e.pos  = e.prod != 0;
            e.ovf  = e.prod > 64'hFFFF_FFFF;
        end
        e.zero = e.prod == 0;
        return e;
    endfunction

    // Scoreboard: judges every cycle from values sampled mid-cycle, before the next edge acts on them.
    always @(negedge clock) begin
        if (!reset) begin
            expq.delete();
            check("rst_prod", bus.out_prod, 0);
            check("rst_flags", {bus.out_valid, bus.out_tag, bus.out_iszero, bus.out_ispositive}, 0);
        end else begin
            check("in_ready", bus.in_ready, (expq.size() < S) | bus.out_ready);
            if (!bus.out_valid) begin
                check("idle_prod", bus.out_prod, 0);
                check("idle_flags", {bus.out_tag, bus.out_iszero, bus.out_ispositive}, 0);
`ifdef MULT_PIPE_OVF_EN
                check("idle_ovf", bus.out_overflow, 0);
`endif
            end
            if (flush) begin
                expq.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        check("out_prod", bus.out_prod, e.prod);
                        check("out_tag", bus.out_tag, e.tag);
                        check("out_zero_pos", {bus.out_iszero, bus.out_ispositive}, {e.zero, e.pos});
`ifdef MULT_PIPE_OVF_EN
                        check("out_ovf", bus.out_overflow, e.ovf);
`endif
                    end
                    seen_tags.push_back(bus.out_tag);
                end
                if (bus.in_valid && bus.in_ready)
                    expq.push_back(model(bus.in_signed, bus.in_a, bus.in_b, bus.in_tag));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
    endtask

    task automatic present(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_signed = sgn;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
    endtask

    // Single op into an empty pipe with out_ready=1; result must show exactly S cycles later.
    task automatic send_lit(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, input logic [63:0] ep, input logic ez, input logic epos);
        bus.out_ready = 1'b1;
        present(sgn, a, b, tag);
        @(posedge clock); #1;
        idle_inputs();
        for (int c = 1; c <= S; c++) begin
            @(negedge clock);
            check({nm, "_valid"}, bus.out_valid, (c == S));
        end
        check({nm, "_prod"}, bus.out_prod, ep);
        check({nm, "_tag"}, bus.out_tag, tag);
        check({nm, "_flags"}, {bus.out_iszero, bus.out_ispositive}, {ez, epos});
`ifdef MULT_PIPE_OVF_EN
        last_ovf = bus.out_overflow;
`endif
        @(posedge clock); #1;
    endtask

    logic [31:0] va [8] = '{32'h0000_000C, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0003};
    logic [31:0] vb [8] = '{32'h0000_0005, 32'h0000_0006, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'h0000_0011, 32'h9ABC_DEF0, 32'h8000_0000, 32'hFFFF_FFFD};
    logic [7:0]  vs  = 8'b1010_1101;
    logic [7:0]  pat = 8'b1011_0110;

    initial begin
        int idx;
        int guard;
        int quiet;

        idle_inputs();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1 check("rst_release_ready", bus.in_ready, 1);
        @(posedge clock); #1;

        send_lit("basic_signed", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
        send_lit("unsigned_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
        send_lit("signed_ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 64'h1, 1'b0, 1'b1);
        send_lit("edge_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd8, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
        send_lit("zero_op", 1'b1, 32'h0, 32'hFFFF_FFF7, 5'd9, 64'h0, 1'b1, 1'b0);

        // Back-pressure: tags 1..6 against a stalled consumer.
        seen_tags.delete();
        bus.out_ready = 1'b0;
        idx = 1;
        present(1'b0, 32'(idx * 3), 32'(idx + 100), 5'(idx));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.in_ready) idx++;
            @(posedge clock); #1;
            present(1'b0, 32'(idx * 3), 32'(idx + 100), 5'(idx));
        end
        check("bp_accepts", 64'(idx - 1), 3);
        @(negedge clock);
        check("bp_full_ready", bus.in_ready, 0);
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        #1 check("bp_recover", bus.in_ready, 1);
        guard = 0;
        while (idx <= 6 && guard < 20) begin
            @(negedge clock);
            if (bus.in_ready) idx++;
            @(posedge clock); #1;
            if (idx <= 6) present(1'b0, 32'(idx * 3), 32'(idx + 100), 5'(idx));
            else idle_inputs();
            guard++;
        end
        guard = 0;
        while (seen_tags.size() < 6 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        check("bp_count", 64'(seen_tags.size()), 6);
        for (int k = 0; k < 6 && k < seen_tags.size(); k++)
            check("bp_order", seen_tags[k], 5'(k + 1));

        // Mixed stream with an irregular consumer.
        idx = 0;
        guard = 0;
        while ((idx < 8 || expq.size() != 0) && guard < 80) begin
            bus.out_ready = pat[guard % 8];
            if (idx < 8) present(vs[idx], va[idx], vb[idx], 5'(idx + 16));
            else idle_inputs();
            @(negedge clock);
            if (idx < 8 && bus.in_ready) idx++;
            @(posedge clock); #1;
            guard++;
        end
        idle_inputs();
        check("mix_drained", 64'(expq.size()), 0);
        check("mix_in_time", guard < 80, 1);

        // Flush with a full, stalled pipe.
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            present(1'b1, 32'(k), 32'hFFFF_FFF0, 5'(k));
            @(posedge clock); #1;
        end
        present(1'b0, 32'd11, 32'd12, 5'd9);
        flush = 1'b1;
        @(negedge clock);
        check("flushA_ready", bus.in_ready, 0);
        @(posedge clock); #1;
        flush = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.out_valid) quiet++;
        end
        check("flushA_quiet", 64'(quiet), 0);
        @(posedge clock); #1;

        // Flush while the pipe would otherwise accept the new op.
        present(1'b0, 32'd4, 32'd5, 5'd3);
        @(posedge clock); #1;
        present(1'b0, 32'd11, 32'd12, 5'd9);
        flush = 1'b1;
        @(negedge clock);
        check("flushB_ready", bus.in_ready, 1);
        @(posedge clock); #1;
        flush = 1'b0;
        idle_inputs();
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.out_valid) quiet++;
        end
        check("flushB_quiet", 64'(quiet), 0);
        @(posedge clock); #1;

        // Reset while two ops are in flight and the first is at the output.
        bus.out_ready = 1'b1;
        present(1'b0, 32'd10, 32'd20, 5'd1);
        @(posedge clock); #1;
        present(1'b0, 32'd30, 32'd40, 5'd2);
        @(posedge clock); #1;
        idle_inputs();
        @(posedge clock); #1;
        check("rst_mid_pre", bus.out_valid, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_prod", bus.out_prod, 0);
        check("rst_mid_flags", {bus.out_tag, bus.out_iszero, bus.out_ispositive}, 0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        #1 check("rst_mid_ready", bus.in_ready, 1);
        @(posedge clock); #1;
        send_lit("after_rst", 1'b0, 32'd2, 32'd3, 5'd4, 64'd6, 1'b0, 1'b1);

`ifdef MULT_PIPE_OVF_EN
        send_lit("ovf_sq", 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd10, 64'h1_0000_0000, 1'b0, 1'b1);
        check("ovf_flag", last_ovf, 1);
        send_lit("ovf_none", 1'b1, 32'hFFFF_8000, 32'h0001_0000, 5'd11, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
        check("ovf_clear", last_ovf, 0);
`endif

        repeat (2) @(posedge clock);
        check("final_empty", 64'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised, elastic, pipelined integer multiplier for the execute-side multiply path.
- Accepts one operand pair per cycle with a destination tag and a signed/unsigned mode bit.
- Produces the full 2*WIDTH-bit product, a zero flag and a strictly-positive flag after STAGES cycles.
- Valid/ready handshake on both sides, back-pressure through every stage, synchronous flush.

Parameters:
- WIDTH, 32, operand width in bits (>= 4)
- STAGES, 3, pipeline depth and minimum latency in cycles (>= 2)
- TAG_W, 5, destination-tag width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operand pair present
- in_ready  output  1  pipeline can accept this cycle
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_tag  input  TAG_W  destination register tag
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_prod  output  2*WIDTH  full product
- out_tag  output  TAG_W  tag of the result
- out_iszero  output  1  product == 0
- out_ispositive  output  1  product > 0

Behaviour:
- Reset: reset=0 clears every stage valid bit and every data register to 0, immediately and asynchronously. All outputs read 0 except in_ready, which is 1 once reset is released.
- Stages are numbered 0..STAGES-1. Each stage holds a valid bit v[i] and data.
- Advance rule: adv[STAGES-1] = v[STAGES-1] & out_ready. For i < STAGES-1, adv[i] = v[i] & (~v[i+1] | adv[i+1]).
- in_ready = ~v[0] | adv[0]. It is combinational and does not depend on in_valid.
- Accept: the pair is accepted when in_valid & in_ready.
- Stage 0, loaded on accept:
  - Latches the tag and the mode bit.
  - Computes neg_a / neg_b from the operand MSB when in_signed=1, else 0.
  - Stores |a| and |b| as WIDTH-bit unsigned values. The magnitude of the most negative value is 2^(WIDTH-1) and fits.
  - iszero = (a==0) | (b==0).
  - neg = neg_a ^ neg_b.
- Stage 1: unsigned product of the two magnitudes, 2*WIDTH bits, with flags carried forward.
- Stages 2..STAGES-1: pure delay registers, present so synthesis can retime the multiply.
- Final stage output:
  - out_prod = neg ? -mag_prod : mag_prod, computed modulo 2^(2*WIDTH).
  - out_iszero = iszero.
  - out_ispositive = ~iszero & ~neg. Zero is never positive, and an unsigned nonzero product is always positive.
- Bubbles: when a stage receives no data (upstream not advancing but the stage drains), v clears and its data registers load 0. When a stage stalls (v=1 & ~adv), its data holds unchanged.
- out_valid = v[STAGES-1]. All out_* data is 0 whenever out_valid=0.
- Latency: with out_ready held 1, a pair accepted in cycle n gives out_valid=1 in cycle n+STAGES. Throughput is 1 per cycle.
- Full pipeline with out_ready=0: in_ready drops to 0 only when all STAGES valid bits are set. Interior bubbles are squeezed out first.
- Same-cycle drain and accept on a full pipeline: all stages advance and in_ready stays 1. There is no bubble.
- flush=1:
  - Clears all v[] and data at the clock edge.
  - An input presented in the same cycle is discarded, although in_ready still reads as computed.
  - flush has priority over advance.
- Reset asserted mid-operation drops every in-flight result. No partial output is produced.
- Signed edge case: (-2^(W-1)) * (-2^(W-1)) = 2^(2W-2) must be represented correctly in out_prod.

Optional Feature:
- Macro: MULT_PIPE_OVF_EN.
- Defined:
  - Adds output port out_overflow (1 bit), pipelined with the other flags.
  - It is set when the product does not fit in WIDTH bits.
  - Signed mode: out_prod[2W-1:W-1] is not all-equal.
  - Unsigned mode: out_prod[2W-1:W] != 0.
  - It is 0 when out_valid=0 and is reset to 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Basic signed: WIDTH=32, STAGES=3, out_ready=1. Send a=7, b=-3, signed, tag=5 in cycle 0 -> cycle 3: out_valid=1, out_prod=64'hFFFF_FFFF_FFFF_FFEB, tag=5, iszero=0, ispositive=0.
- Unsigned vs signed: a=b=32'hFFFF_FFFF. Unsigned gives out_prod=64'hFFFF_FFFE_0000_0001 with ispositive=1. Signed gives 64'h1 with ispositive=1.
- Edge and zero: a=b=32'h8000_0000 signed -> 64'h4000_0000_0000_0000, ispositive=1. a=0, b=-9 -> out_prod=0, iszero=1, ispositive=0.
- Back-pressure: stream tags 1..6 back-to-back with out_ready=0 -> in_ready falls after 3 accepts. Then raise out_ready -> tags 1..6 appear in order with no loss or duplication, and in_ready recovers in the same cycle.
- Flush: accept 3 ops, assert flush for 1 cycle together with in_valid -> next cycle all v=0 and out_valid stays 0. The op presented during flush never appears.
- Reset mid-stream: reset=0 while 2 ops are in flight -> out_* read 0 immediately. After release, a=2, b=3 gives 6 with latency 3. With MULT_PIPE_OVF_EN defined, a=32'h0001_0000 squared unsigned gives out_overflow=1.
